// File: rtl/sharp_pkg.sv
// Shared definitions for the image-sharpening extension: word width, buffer depth
// and a constant-foldable ceiling-log2 helper.
package sharp_pkg;

  localparam int unsigned SHARP_WIDTH = 16;
  localparam int unsigned ODI_DEPTH   = 4;

  typedef logic [SHARP_WIDTH-1:0] pixel_t;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(n)) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/odi_fifo_mem.sv
// DEPTH x WIDTH register array: one synchronous write port and one combinational
// read port. The array has no reset.
module odi_fifo_mem
  import sharp_pkg::*;
#(
  parameter int unsigned WIDTH = SHARP_WIDTH,
  parameter int unsigned DEPTH = ODI_DEPTH,
  parameter int unsigned PtrW  = clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [PtrW-1:0]  i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [PtrW-1:0]  i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/odi_buffer.sv
// Return-path FIFO between the sharpening datapath and the DLX read mux.
// Handshake flags are decoded from the stored count only, so no input reaches an output.
module odi_buffer
  import sharp_pkg::*;
#(
  parameter int unsigned WIDTH = SHARP_WIDTH,
  parameter int unsigned DEPTH = ODI_DEPTH
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic [WIDTH-1:0]        IN_DATA,
  input  logic                    IN_VALID,
  output logic                    IN_READY,
  output logic [WIDTH-1:0]        OUT_DATA,
  output logic                    OUT_VALID,
  input  logic                    OUT_READ,
  output logic [clog2(DEPTH):0]   COUNT,
  output logic                    UNDERFLOW,
  input  logic                    CLR_ERR
);

  localparam int unsigned PtrW = clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [PtrW-1:0] r_wptr;
  logic [PtrW-1:0] r_rptr;
  logic [CntW-1:0] r_count;
  logic            r_underflow;

  logic [PtrW-1:0] w_wptr_d;
  logic [PtrW-1:0] w_rptr_d;
  logic [CntW-1:0] w_count_d;
  logic            w_underflow_d;
  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;
  logic            w_uf_set;

  assign w_full   = (r_count == CntW'(DEPTH));
  assign w_empty  = (r_count == '0);
  assign w_push   = IN_VALID & ~w_full;
  assign w_pop    = OUT_READ & ~w_empty;
  assign w_uf_set = OUT_READ & w_empty;

  always_comb begin
    w_wptr_d      = r_wptr;
    w_rptr_d      = r_rptr;
    w_count_d     = r_count;
    w_underflow_d = r_underflow;
    // DEPTH is a power of two, so the pointers wrap on plain overflow
    if (w_push) begin
      w_wptr_d = r_wptr + PtrW'(1);
    end
    if (w_pop) begin
      w_rptr_d = r_rptr + PtrW'(1);
    end
    unique case ({w_push, w_pop})
      2'b10:   w_count_d = r_count + CntW'(1);
      2'b01:   w_count_d = r_count - CntW'(1);
      default: w_count_d = r_count;
    endcase
    // A set in the same cycle as a clear takes priority
    if (w_uf_set) begin
      w_underflow_d = 1'b1;
    end else if (CLR_ERR) begin
      w_underflow_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_underflow <= 1'b0;
    end else begin
      r_wptr      <= w_wptr_d;
      r_rptr      <= w_rptr_d;
      r_count     <= w_count_d;
      r_underflow <= w_underflow_d;
    end
  end

  odi_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .PtrW  (PtrW)
  ) u_mem (
    .i_clk   (CLK),
    .i_we    (w_push),
    .i_waddr (r_wptr),
    .i_wdata (IN_DATA),
    .i_raddr (r_rptr),
    .o_rdata (OUT_DATA)
  );

  assign IN_READY  = ~w_full;
  assign OUT_VALID = ~w_empty;
  assign COUNT     = r_count;
  assign UNDERFLOW = r_underflow;

endmodule

// File: tb/tb_odi_buffer.sv
// Bench for odi_buffer: queue-based reference model checked every cycle, plus
// directed sequences with literal expectations.
module tb_odi_buffer;

  localparam int unsigned DEPTH = 4;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [15:0] IN_DATA = '0;
  logic        IN_VALID = 1'b0;
  logic        IN_READY;
  logic [15:0] OUT_DATA;
  logic        OUT_VALID;
  logic        OUT_READ = 1'b0;
  logic [2:0]  COUNT;
  logic        UNDERFLOW;
  logic        CLR_ERR = 1'b0;

  int tests = 0;
  int failed = 0;
  bit chk_en = 1'b0;

  logic [15:0] q[$];
  bit          m_uf = 1'b0;
  bit          m_push;
  bit          m_pop;

  odi_buffer #(
    .WIDTH (16),
    .DEPTH (DEPTH)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .IN_DATA   (IN_DATA),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .OUT_DATA  (OUT_DATA),
    .OUT_VALID (OUT_VALID),
    .OUT_READ  (OUT_READ),
    .COUNT     (COUNT),
    .UNDERFLOW (UNDERFLOW),
    .CLR_ERR   (CLR_ERR)
  );

  initial forever #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests = tests + 1;
    if (act !== exp) begin
      failed = failed + 1;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Reference model: a plain queue of accepted words plus the sticky error bit
  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      q.delete();
      m_uf = 1'b0;
    end else begin
      m_push = IN_VALID && (q.size() < DEPTH);
      m_pop  = OUT_READ && (q.size() > 0);
      if (OUT_READ && q.size() == 0) m_uf = 1'b1;
      else if (CLR_ERR) m_uf = 1'b0;
      if (m_pop) void'(q.pop_front());
      if (m_push) q.push_back(IN_DATA);
    end
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      chk("cmp_count", 32'(COUNT), 32'(q.size()));
      chk("cmp_in_ready", 32'(IN_READY), 32'(q.size() != DEPTH));
      chk("cmp_out_valid", 32'(OUT_VALID), 32'(q.size() != 0));
      chk("cmp_underflow", 32'(UNDERFLOW), 32'(m_uf));
      if (q.size() > 0) chk("cmp_out_data", 32'(OUT_DATA), 32'(q[0]));
    end
  end

  initial begin
    // Reset held over edges, with a push attempt that must be ignored
    IN_VALID = 1'b1;
    IN_DATA  = 16'hDEAD;
    tick();
    tick();
    chk_en = 1'b1;
    chk("rst_count", 32'(COUNT), 0);
    chk("rst_in_ready", 32'(IN_READY), 1);
    chk("rst_out_valid", 32'(OUT_VALID), 0);
    chk("rst_underflow", 32'(UNDERFLOW), 0);
    RESET    = 1'b0;
    IN_VALID = 1'b0;
    tick();
    chk("rst_push_ignored", 32'(COUNT), 0);

    // Fill and drain
    for (int i = 1; i <= 4; i++) begin
      IN_VALID = 1'b1;
      IN_DATA  = 16'(i);
      tick();
    end
    chk("fill_count", 32'(COUNT), 4);
    chk("fill_in_ready", 32'(IN_READY), 0);
    chk("model_fill", 32'(q.size()), 4);
    IN_DATA = 16'h0005;
    tick();
    IN_VALID = 1'b0;
    chk("fill_fifth_ignored", 32'(COUNT), 4);
    OUT_READ = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("drain_data", 32'(OUT_DATA), 32'(i));
      tick();
    end
    OUT_READ = 1'b0;
    chk("drain_out_valid", 32'(OUT_VALID), 0);
    chk("drain_underflow", 32'(UNDERFLOW), 0);

    // Simultaneous push and pop when full
    for (int i = 0; i < 4; i++) begin
      IN_VALID = 1'b1;
      IN_DATA  = 16'h0010 + 16'(i);
      tick();
    end
    IN_DATA  = 16'h0099;
    OUT_READ = 1'b1;
    tick();
    IN_VALID = 1'b0;
    chk("full_pp_count", 32'(COUNT), 3);
    chk("full_pp_head", 32'(OUT_DATA), 32'h11);
    for (int i = 1; i < 4; i++) begin
      chk("full_pp_drain", 32'(OUT_DATA), 32'h10 + 32'(i));
      tick();
    end
    OUT_READ = 1'b0;
    chk("full_pp_empty", 32'(COUNT), 0);

    // Simultaneous push and pop at COUNT=2
    IN_VALID = 1'b1;
    IN_DATA  = 16'h0020;
    tick();
    IN_DATA = 16'h0021;
    tick();
    IN_DATA  = 16'h0022;
    OUT_READ = 1'b1;
    tick();
    IN_VALID = 1'b0;
    chk("two_pp_count", 32'(COUNT), 2);
    chk("two_pp_head", 32'(OUT_DATA), 32'h21);
    tick();
    chk("two_pp_next", 32'(OUT_DATA), 32'h22);
    tick();
    OUT_READ = 1'b0;
    chk("two_pp_empty", 32'(COUNT), 0);

    // Wrap-around: one push and one pop per cycle
    IN_VALID = 1'b1;
    IN_DATA  = 16'hA000;
    tick();
    for (int i = 1; i < 10; i++) begin
      chk("wrap_data", 32'(OUT_DATA), 32'hA000 + 32'(i - 1));
      chk("wrap_count", 32'(COUNT), 1);
      IN_DATA  = 16'hA000 + 16'(i);
      OUT_READ = 1'b1;
      tick();
    end
    IN_VALID = 1'b0;
    chk("wrap_last", 32'(OUT_DATA), 32'hA009);
    tick();
    OUT_READ = 1'b0;
    chk("wrap_empty", 32'(COUNT), 0);

    // Underflow set, set-beats-clear, clear
    OUT_READ = 1'b1;
    tick();
    OUT_READ = 1'b0;
    chk("uf_set", 32'(UNDERFLOW), 1);
    chk("uf_count", 32'(COUNT), 0);
    OUT_READ = 1'b1;
    CLR_ERR  = 1'b1;
    tick();
    OUT_READ = 1'b0;
    chk("uf_set_wins", 32'(UNDERFLOW), 1);
    tick();
    CLR_ERR = 1'b0;
    chk("uf_clear", 32'(UNDERFLOW), 0);
    chk("model_uf", 32'(m_uf), 0);

    // Asynchronous reset mid-stream with COUNT=3 and UNDERFLOW set
    OUT_READ = 1'b1;
    tick();
    OUT_READ = 1'b0;
    for (int i = 0; i < 3; i++) begin
      IN_VALID = 1'b1;
      IN_DATA  = 16'h0B00 + 16'(i);
      tick();
    end
    chk("mid_count", 32'(COUNT), 3);
    chk("mid_uf", 32'(UNDERFLOW), 1);
    #2;
    RESET = 1'b1;
    #1;
    chk("arst_count", 32'(COUNT), 0);
    chk("arst_out_valid", 32'(OUT_VALID), 0);
    chk("arst_in_ready", 32'(IN_READY), 1);
    chk("arst_underflow", 32'(UNDERFLOW), 0);
    tick();
    RESET    = 1'b0;
    IN_VALID = 1'b0;
    chk("arst_push_ignored", 32'(COUNT), 0);
    IN_VALID = 1'b1;
    IN_DATA  = 16'h1234;
    tick();
    IN_VALID = 1'b0;
    chk("arst_readback", 32'(OUT_DATA), 32'h1234);
    OUT_READ = 1'b1;
    tick();
    OUT_READ = 1'b0;

    // Random backpressure stream against the model
    for (int i = 0; i < 1000; i++) begin
      IN_VALID = 1'($urandom_range(0, 1));
      IN_DATA  = 16'($urandom);
      OUT_READ = ($urandom_range(0, 9) < 5);
      CLR_ERR  = ($urandom_range(0, 15) == 0);
      tick();
    end
    IN_VALID = 1'b0;
    CLR_ERR  = 1'b0;
    OUT_READ = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    OUT_READ = 1'b0;
    CLR_ERR  = 1'b1;
    tick();
    CLR_ERR = 1'b0;
    chk("final_count", 32'(COUNT), 0);
    chk("final_uf", 32'(UNDERFLOW), 0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/odi_buffer.md
# odi_buffer

Return-path buffer for the image-sharpening extension. It accepts 16-bit result pixels from the sharpening datapath over a valid/ready handshake and holds them in a small FIFO. The DLX core drains them one word per read strobe. It is the output-direction counterpart of the input data buffer that feeds operands into the extension, and it sits between the sharpening datapath output and the DLX data-bus read mux.

## Interface
Parameters:
- WIDTH, 16, data word width in bits
- DEPTH, 4, number of FIFO entries; must be a power of two, minimum 2

Ports:
- CLK  in  1  single system clock; all state changes on its rising edge
- RESET  in  1  asynchronous, active-high reset
- IN_DATA  in  WIDTH  result pixel from the sharpening datapath
- IN_VALID  in  1  IN_DATA is valid this cycle
- IN_READY  out  1  buffer can accept a word this cycle
- OUT_DATA  out  WIDTH  word at the FIFO head, presented to the DLX read mux
- OUT_VALID  out  1  OUT_DATA holds a valid word
- OUT_READ  in  1  DLX read strobe; consumes the head word
- COUNT  out  log2(DEPTH)+1  number of stored words, 0..DEPTH
- UNDERFLOW  out  1  sticky error flag: a read was attempted while the buffer was empty
- CLR_ERR  in  1  clears UNDERFLOW

## Operation
- **Push:** a word is written when IN_VALID and IN_READY are both high at a rising edge of CLK. The write pointer increments modulo DEPTH.
- **IN_READY:** equals (COUNT != DEPTH). It is decoded from registered state only and never depends on OUT_READ in the same cycle.
- **Pop:** occurs when OUT_READ and OUT_VALID are both high. The read pointer increments modulo DEPTH.
- **OUT_VALID:** equals (COUNT != 0).
- **OUT_DATA:** always shows the memory entry at the read pointer.
- **Pointers:** both are log2(DEPTH) bits wide and wrap naturally, with no extra wrap bit. Full and empty are distinguished by COUNT.
- **COUNT update:** increments on a push only, decrements on a pop only, and is unchanged on a simultaneous push and pop.
- **Simultaneous push and pop when full:** the pop is accepted. The push is not, because IN_READY is already low. COUNT becomes DEPTH-1.
- **Simultaneous push and pop when empty:** the pop is not possible because OUT_VALID is low. The push is accepted and COUNT becomes 1.
- **Underflow:**
  - OUT_READ high while OUT_VALID is low sets UNDERFLOW on that edge. Pointers and COUNT are unchanged.
  - CLR_ERR high clears UNDERFLOW.
  - If a set and a clear occur in the same cycle, the set wins.
- **Reset:** RESET clears both pointers, COUNT and UNDERFLOW immediately and asynchronously. Memory contents are not cleared.
- **Reset mid-operation:** all stored words are discarded. A push coincident with the RESET deassertion edge is ignored.

## Timing
- **Reset values:** IN_READY=1, OUT_VALID=0, COUNT=0, UNDERFLOW=0. OUT_DATA is undefined but stable. These values hold while RESET is high.
- **Write-to-read latency:** 1 cycle. A word pushed at edge N is visible on OUT_DATA, with OUT_VALID=1, after edge N when the FIFO was empty.
- **Read behaviour:** OUT_DATA advances to the next entry in the cycle after a pop edge. There is no bubble when COUNT is 2 or more.
- **Handshake and throughput:** sustained one push and one pop per cycle is supported with no loss of throughput.
- **Output register dependencies:** COUNT, UNDERFLOW, IN_READY and OUT_VALID depend only on state registers, with no combinational input-to-output paths. OUT_DATA depends only on state registers and memory.

## Structure
- **Shared package `sharp_pkg`:**
  - constants SHARP_WIDTH=16 and ODI_DEPTH=4
  - a pointer-width function, clog2
  - a pixel word typedef
- **Sub-module `odi_fifo_mem`:** DEPTH x WIDTH register array.
  - one synchronous write port, with write enable and address
  - one combinational read port
  - no reset on the array
- **Control logic** (pointers, count, flags) lives in odi_buffer itself.

## Test plan
- **Reset:** assert RESET mid-stream with COUNT=3 -> COUNT=0, OUT_VALID=0, IN_READY=1, UNDERFLOW=0 with no clock edge needed. The next push of 0x1234 is read back first.
- **Fill and drain:** push 0x0001..0x0004 -> COUNT=4 and IN_READY=0. A fifth push of 0x0005 is ignored. Drain yields 0x0001, 0x0002, 0x0003, 0x0004 in order, then OUT_VALID=0.
- **Wrap-around:** run 10 push/pop pairs at DEPTH=4 with data 0xA000+i -> every word is read back in order, COUNT never exceeds 1, and there is 1-cycle latency per word.
- **Simultaneous push and pop:**
  - With COUNT=4, hold IN_VALID and OUT_READ high for one cycle -> COUNT=3 and the head is popped.
  - At COUNT=2 -> COUNT stays 2 and order is preserved.
- **Underflow:**
  - OUT_READ while empty -> UNDERFLOW=1, COUNT remains 0.
  - CLR_ERR together with another empty read -> UNDERFLOW stays 1.
  - CLR_ERR alone -> UNDERFLOW=0.
- **Backpressure stream:** random IN_VALID and OUT_READ over 1000 cycles against a scoreboard model -> no loss, duplication or reordering, and COUNT always matches the model.
